lm_sm_sequencer: RTL and testbench
==================================

// Module: lm_sm_sequencer
// PURPOSE
//  Multi-cycle controller for the LM/SM (load/store multiple) instructions.
//  Walks the 8-bit register mask in ascending index order and issues one memory access per set bit.
//  Drives the single register-file write port (LM) or read port (SM), and stalls the upstream
//  pipeline until the sequence completes.
// PARAMETERS
//  DATA_W  16  data and memory address width
//  NREG    8   number of architectural registers (mask width)
//  RADDR_W 3   register index width, log2(NREG)
// PORTS
//  clk           in   1       clock; all state changes on rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       request; accepted only in IDLE
//  is_load       in   1       1 = LM (mem->reg), 0 = SM (reg->mem); sampled with start
//  reg_mask      in   NREG    bit i set => Ri transferred; sampled with start
//  base_addr     in   DATA_W  first memory address (Ra value); sampled with start
//  mem_ready     in   1       memory accepts/completes the current access this cycle
//  mem_rd_data   in   DATA_W  load data, valid when mem_ready=1
//  rf_read_data  in   DATA_W  register-file read data for rf_read_addr
//  mem_addr      out  DATA_W  current access address
//  mem_rd_en     out  1       read request (LM)
//  mem_wr_en     out  1       write request (SM)
//  mem_wr_data   out  DATA_W  = rf_read_data (combinational pass-through)
//  rf_read_addr  out  RADDR_W register being stored (SM)
//  rf_write_en   out  1       register-file write enable (LM)
//  rf_write_dest out  RADDR_W register being loaded
//  rf_write_data out  DATA_W  = mem_rd_data (combinational)
//  busy          out  1       sequence in progress (ACCESS or DONE)
//  stall         out  1       busy | (start & state==IDLE); freezes fetch/decode
//  done          out  1       one-cycle completion pulse
// BEHAVIOUR
//  - FSM states:
//    - IDLE: on start, latch is_load, mask, base into mask_q/addr_q.
//      - mask==0 -> DONE; else -> ACCESS with cur = lowest set bit.
//    - ACCESS: mem_rd_en=is_load_q, mem_wr_en=~is_load_q, mem_addr=addr_q, rf_read_addr=cur,
//      rf_write_dest=cur.
//      - mem_ready=0: hold all outputs and state; unlimited wait.
//      - mem_ready=1: rf_write_en = is_load_q & (cur!=7) in the same cycle; clear mask_q[cur];
//        addr_q <= addr_q+1 (mod 2^DATA_W, wraps FFFF->0000);
//        cur <= next lowest set bit; if no bits remain -> DONE.
//    - DONE: done=1 for exactly one cycle, busy=1, no memory/rf enables -> IDLE.
//  - R7 is the PC. LM with bit 7 set performs the read and advances the address, but
//    rf_write_en stays 0. SM with bit 7 set stores rf_read_data of R7 normally.
//  - Address advances only per processed (set) bit; skipped bits consume no cycles.
//  - Latency with mem_ready tied 1 and N set bits (start accepted in cycle 0):
//    - accesses in cycles 1..N; done in cycle N+1; IDLE in cycle N+2.
//    - mask==0: done in cycle 1, no memory enables.
//  - start outside IDLE is ignored (no re-latch); start coincident with done is ignored.
//  - Reset, at any time including mid-sequence: state=IDLE immediately (asynchronous).
//    - all outputs 0: enables, busy, stall (unless start), done, mem_addr, rf addrs.
//    - mask_q=0, addr_q=0.
//    - register writes already committed remain; no done pulse.
//  - mem_rd_en and mem_wr_en are never both 1; rf_write_en is never 1 outside ACCESS.
// TESTING
//  1. LM, mask=8'b0000_0101, base=0x0010, mem_ready=1 -> rf_write R0<=M[0x0010] cyc1,
//     R2<=M[0x0011] cyc2, done cyc3, stall cyc0-3.
//  2. SM, mask=0xFF, base=0xFFFE -> 8 writes, addr FFFE,FFFF,0000..0005,
//     rf_read_addr 0..7, done cyc9.
//  3. mask=0x00, start -> no mem_rd_en/mem_wr_en ever, done=1 cyc1, busy=0 cyc2.
//  4. LM mask=0x03, mem_ready low 2 cycles per access -> mem_addr/rd_en held steady,
//     rf_write_en only on ready cycles, done 1 cycle after 2nd ready.
//  5. LM mask=0x80 -> one read at base, rf_write_en stays 0, done cyc2;
//     start pulsed during busy -> ignored.
//  6. rst raised after first LM write of mask=0x0F -> all outputs 0 same cycle, no done;
//     new start after release runs full sequence.

Source files
------------

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: multi-cycle controller for LM/SM (load/store multiple).
// Walks the register mask from the lowest index upward and issues one memory
// access per set bit. It drives the register-file write port (LM) or read
// port (SM) and stalls the upstream pipeline while a sequence is in flight.
module lm_sm_sequencer #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_load,
  input  logic [NREG-1:0]    reg_mask,
  input  logic [DATA_W-1:0]  base_addr,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rd_data,
  input  logic [DATA_W-1:0]  rf_read_data,
  output logic [DATA_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic [RADDR_W-1:0] rf_read_addr,
  output logic               rf_write_en,
  output logic [RADDR_W-1:0] rf_write_dest,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic               busy,
  output logic               stall,
  output logic               done
);

  // The highest register index is the PC; LM never writes it back.
  localparam logic [RADDR_W-1:0] PC_IDX = RADDR_W'(NREG - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                is_load_q;
  logic [NREG-1:0]     mask_q;
  logic [DATA_W-1:0]   addr_q;
  logic [RADDR_W-1:0]  cur_q;

  logic [NREG-1:0]     mask_rest;
  logic [RADDR_W-1:0]  cur_first;
  logic [RADDR_W-1:0]  cur_next;
  logic                accept;
  logic                step;

  // Index of the lowest set bit; an empty mask returns 0, but callers only
  // use the result when at least one bit is set.
  function automatic logic [RADDR_W-1:0] lowest_set(input logic [NREG-1:0] m);
    logic [RADDR_W-1:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) idx = RADDR_W'(i);
    end
    return idx;
  endfunction

  // Mask bookkeeping: what remains after the current access and where to go next.
  always_comb begin
    mask_rest = mask_q & ~(NREG'(1) << cur_q);
    cur_first = lowest_set(reg_mask);
    cur_next  = lowest_set(mask_rest);
    accept    = (state == ST_IDLE) && start;
    step      = (state == ST_ACCESS) && mem_ready;
  end

  // State register; reset drops straight back to IDLE without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is only honoured in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (reg_mask == '0) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ready && (mask_rest == '0)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequence registers: latch the request on accept, advance on each completed access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_load_q <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      cur_q     <= '0;
    end else if (accept) begin
      is_load_q <= is_load;
      mask_q    <= reg_mask;
      addr_q    <= base_addr;
      cur_q     <= cur_first;
    end else if (step) begin
      mask_q    <= mask_rest;
      addr_q    <= addr_q + DATA_W'(1);
      cur_q     <= cur_next;
    end
  end

  // Output decode; addresses and enables are only driven during ACCESS.
  always_comb begin
    mem_addr      = '0;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    rf_read_addr  = '0;
    rf_write_en   = 1'b0;
    rf_write_dest = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      ST_ACCESS: begin
        mem_addr      = addr_q;
        mem_rd_en     = is_load_q;
        mem_wr_en     = ~is_load_q;
        rf_read_addr  = cur_q;
        rf_write_dest = cur_q;
        rf_write_en   = is_load_q && mem_ready && (cur_q != PC_IDX);
        busy          = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
    stall         = busy | (start && (state == ST_IDLE));
    mem_wr_data   = rf_read_data;
    rf_write_data = mem_rd_data;
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed bench for lm_sm_sequencer with a queue-based
// transaction model and a per-cycle compare process.
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        mem_ready;
  logic [15:0] mem_rd_data;
  logic [15:0] rf_read_data;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [2:0]  rf_read_addr;
  logic        rf_write_en;
  logic [2:0]  rf_write_dest;
  logic [15:0] rf_write_data;
  logic        busy;
  logic        stall;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int idle_cyc = -1;
  int done_cnt = 0;
  int en_cnt = 0;
  int rd_cycles = 0;
  int stall_cnt = 0;

  logic [15:0] wr_log[$];
  logic [15:0] wd_log[$];
  logic [15:0] rd_log[$];
  logic [2:0]  rfw_log[$];
  logic [15:0] rfwd_log[$];

  typedef struct {
    logic [2:0]  r;
    logic [15:0] a;
  } acc_t;

  acc_t q[$];
  bit   m_done = 1'b0;
  bit   m_load = 1'b0;

  lm_sm_sequencer #(.DATA_W(16), .NREG(8), .RADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_mask(reg_mask),
    .base_addr(base_addr), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .rf_read_data(rf_read_data), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .rf_read_addr(rf_read_addr),
    .rf_write_en(rf_write_en), .rf_write_dest(rf_write_dest),
    .rf_write_data(rf_write_data), .busy(busy), .stall(stall), .done(done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Memory returns a pattern derived from the address; register file returns one derived from the index
  assign mem_rd_data  = mem_addr ^ 16'hA5A5;
  assign rf_read_data = 16'h1000 + 16'(rf_read_addr) * 16'h0101;

  // Cycle counter, advanced on each rising edge
  always @(posedge clk) cyc++;

  // Transaction model: an accepted request becomes a list of (register, address) accesses
  always @(posedge clk or posedge rst) begin : model
    logic [15:0] a;
    if (rst) begin
      q.delete();
      m_done = 1'b0;
      m_load = 1'b0;
    end else if (q.size() > 0) begin
      if (mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      m_load = is_load;
      a = base_addr;
      for (int i = 0; i < 8; i++) begin
        if (reg_mask[i]) begin
          q.push_back('{r: 3'(i), a: a});
          a = a + 16'd1;
        end
      end
      if (q.size() == 0) m_done = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against the model on every falling edge
  always @(negedge clk) begin : compare
    logic        e_rd, e_wr, e_we, e_busy, e_stall, e_done;
    logic [15:0] e_addr;
    logic [2:0]  e_reg;
    e_rd = 0; e_wr = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = '0; e_reg = '0;
    e_stall = start;
    if (!rst && q.size() > 0) begin
      e_addr  = q[0].a;
      e_reg   = q[0].r;
      e_rd    = m_load;
      e_wr    = !m_load;
      e_we    = m_load && mem_ready && (q[0].r != 3'd7);
      e_busy  = 1'b1;
      e_stall = 1'b1;
    end else if (!rst && m_done) begin
      e_busy  = 1'b1;
      e_stall = 1'b1;
      e_done  = 1'b1;
    end
    checkOutput("mem_addr", 32'(mem_addr), 32'(e_addr));
    checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    checkOutput("rf_read_addr", 32'(rf_read_addr), 32'(e_reg));
    checkOutput("rf_write_dest", 32'(rf_write_dest), 32'(e_reg));
    checkOutput("rf_write_en", 32'(rf_write_en), 32'(e_we));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("stall", 32'(stall), 32'(e_stall));
    checkOutput("done", 32'(done), 32'(e_done));
    if (e_wr) checkOutput("mem_wr_data", 32'(mem_wr_data), 32'(16'h1000 + 16'(e_reg) * 16'h0101));
    if (e_we) checkOutput("rf_write_data", 32'(rf_write_data), 32'(e_addr ^ 16'hA5A5));
  end

  // Event logger feeding the hand-computed per-test expectations
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_log.push_back(mem_addr);
      wd_log.push_back(mem_wr_data);
    end
    if (mem_rd_en && mem_ready) rd_log.push_back(mem_addr);
    if (mem_rd_en) rd_cycles++;
    if (mem_rd_en || mem_wr_en) en_cnt++;
    if (rf_write_en) begin
      rfw_log.push_back(rf_write_dest);
      rfwd_log.push_back(rf_write_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - start_cyc;
    end
    if (stall) stall_cnt++;
  end

  task automatic clearLogs();
    wr_log.delete(); wd_log.delete(); rd_log.delete(); rfw_log.delete(); rfwd_log.delete();
    done_cyc = -1; idle_cyc = -1; done_cnt = 0; en_cnt = 0; rd_cycles = 0; stall_cnt = 0;
  endtask

  task automatic applyStimulus(input bit st, input bit ld, input logic [7:0] m,
                               input logic [15:0] b, input bit rdy);
    @(posedge clk);
    #1;
    start = st; is_load = ld; reg_mask = m; base_addr = b; mem_ready = rdy;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done_cnt > 0 && !busy) && n < budget);
    idle_cyc = cyc - start_cyc;
    checkOutput("seq_timeout", 32'(!(done_cnt > 0 && !busy)), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 0; is_load = 0; reg_mask = '0; base_addr = '0; mem_ready = 1'b1;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // LM mask 0000_0101 from 0x0010
    clearLogs();
    applyStimulus(1, 1, 8'h05, 16'h0010, 1);
    start_cyc = cyc;
    applyStimulus(0, 1, 8'h05, 16'h0010, 1);
    waitIdle(20);
    checkOutput("t1_writes", 32'(rfw_log.size()), 32'd2);
    if (rfw_log.size() == 2) begin
      checkOutput("t1_dest0", 32'(rfw_log[0]), 32'd0);
      checkOutput("t1_dest1", 32'(rfw_log[1]), 32'd2);
      checkOutput("t1_data0", 32'(rfwd_log[0]), 32'h0000A5B5);
      checkOutput("t1_data1", 32'(rfwd_log[1]), 32'h0000A5B4);
    end
    checkOutput("t1_done_cyc", 32'(done_cyc), 32'd3);
    checkOutput("t1_stall_cycles", 32'(stall_cnt), 32'd4);

    // SM all registers from 0xFFFE, address wraps
    clearLogs();
    applyStimulus(1, 0, 8'hFF, 16'hFFFE, 1);
    start_cyc = cyc;
    applyStimulus(0, 0, 8'h00, 16'h0000, 1);
    waitIdle(30);
    checkOutput("t2_writes", 32'(wr_log.size()), 32'd8);
    if (wr_log.size() == 8) begin
      checkOutput("t2_addr0", 32'(wr_log[0]), 32'hFFFE);
      checkOutput("t2_addr1", 32'(wr_log[1]), 32'hFFFF);
      checkOutput("t2_addr2", 32'(wr_log[2]), 32'h0000);
      checkOutput("t2_addr7", 32'(wr_log[7]), 32'h0005);
      checkOutput("t2_data7", 32'(wd_log[7]), 32'h1707);
    end
    checkOutput("t2_reads", 32'(rd_log.size()), 32'd0);
    checkOutput("t2_done_cyc", 32'(done_cyc), 32'd9);

    // Empty mask
    clearLogs();
    applyStimulus(1, 1, 8'h00, 16'h0100, 1);
    start_cyc = cyc;
    applyStimulus(0, 1, 8'h00, 16'h0100, 1);
    waitIdle(10);
    checkOutput("t3_enables", 32'(en_cnt), 32'd0);
    checkOutput("t3_done_cyc", 32'(done_cyc), 32'd1);
    checkOutput("t3_idle_cyc", 32'(idle_cyc), 32'd2);

    // LM mask 0x03 with two wait cycles before each ready
    clearLogs();
    applyStimulus(1, 1, 8'h03, 16'h1234, 0);
    start_cyc = cyc;
    applyStimulus(0, 1, 8'h03, 16'h1234, 0);
    applyStimulus(0, 1, 8'h03, 16'h1234, 0);
    applyStimulus(0, 1, 8'h03, 16'h1234, 1);
    applyStimulus(0, 1, 8'h03, 16'h1234, 0);
    applyStimulus(0, 1, 8'h03, 16'h1234, 0);
    applyStimulus(0, 1, 8'h03, 16'h1234, 1);
    waitIdle(20);
    checkOutput("t4_writes", 32'(rfw_log.size()), 32'd2);
    checkOutput("t4_rd_cycles", 32'(rd_cycles), 32'd6);
    if (rd_log.size() == 2) checkOutput("t4_addr1", 32'(rd_log[1]), 32'h1235);
    checkOutput("t4_done_cyc", 32'(done_cyc), 32'd7);

    // LM of R7 only, with start re-pulsed while busy and alongside done
    clearLogs();
    applyStimulus(1, 1, 8'h80, 16'h0300, 1);
    start_cyc = cyc;
    applyStimulus(1, 0, 8'h01, 16'h0700, 1);
    applyStimulus(1, 0, 8'h01, 16'h0700, 1);
    applyStimulus(0, 0, 8'h01, 16'h0700, 1);
    waitIdle(10);
    repeat (3) @(negedge clk);
    checkOutput("t5_reads", 32'(rd_log.size()), 32'd1);
    if (rd_log.size() == 1) checkOutput("t5_addr", 32'(rd_log[0]), 32'h0300);
    checkOutput("t5_writes", 32'(rfw_log.size()), 32'd0);
    checkOutput("t5_done_cyc", 32'(done_cyc), 32'd2);
    checkOutput("t5_done_count", 32'(done_cnt), 32'd1);
    checkOutput("t5_stores", 32'(wr_log.size()), 32'd0);

    // Reset mid-sequence after the first LM write, then a clean rerun
    clearLogs();
    applyStimulus(1, 1, 8'h0F, 16'h0040, 1);
    start_cyc = cyc;
    applyStimulus(0, 1, 8'h0F, 16'h0040, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("t6_rf_we", 32'(rf_write_en), 32'd0);
    checkOutput("t6_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("t6_dest", 32'(rf_write_dest), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6_writes_before_rst", 32'(rfw_log.size()), 32'd1);
    checkOutput("t6_no_done", 32'(done_cnt), 32'd0);
    clearLogs();
    applyStimulus(1, 1, 8'h0F, 16'h0040, 1);
    start_cyc = cyc;
    applyStimulus(0, 1, 8'h0F, 16'h0040, 1);
    waitIdle(20);
    checkOutput("t6_rerun_writes", 32'(rfw_log.size()), 32'd4);
    if (rfw_log.size() == 4) checkOutput("t6_rerun_dest3", 32'(rfw_log[3]), 32'd3);
    checkOutput("t6_rerun_done_cyc", 32'(done_cyc), 32'd5);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
